// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared constants for the Decode stage: register index width,
//               the zero register, the NOP encoding and major opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;
    localparam logic [31:0]          NOP_INSTR = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : NREGS x WIDTH register file, two combinational read ports,
//               one write port from Writeback; r0 hardwired to zero.
//               Optional write-through bypass: DECODE_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
    import decode_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];
    logic             wr_en;

    assign wr_en = we && (waddr != AW'(REG_ZERO));

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    // wr_en already excludes r0, so a bypassed read of r0 still returns zero
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else if (raddr1 != AW'(REG_ZERO)) begin
            rdata1 = mem_q[raddr1];
        end
        if (wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else if (raddr2 != AW'(REG_ZERO)) begin
            rdata2 = mem_q[raddr2];
        end
    end
`else
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != AW'(REG_ZERO)) begin
            rdata1 = mem_q[raddr1];
        end
        if (raddr2 != AW'(REG_ZERO)) begin
            rdata2 = mem_q[raddr2];
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
// Module      : decode
// Description : IF/ID pipeline register plus Decode-stage datapath: register
//               file, immediate, branch target and early branch compare.
//               Optional write-through bypass: DECODE_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module decode
    import decode_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instrF,
    input  logic [WIDTH-1:0]         pcplus4F,
    input  logic                     stallD,
    input  logic                     flushD,
    input  logic                     regwriteW,
    input  logic [$clog2(NREGS)-1:0] writeregW,
    input  logic [WIDTH-1:0]         resultW,
    input  logic                     forwardAD,
    input  logic                     forwardBD,
    input  logic [WIDTH-1:0]         aluoutM,
    output logic [31:0]              instrD,
    output logic [WIDTH-1:0]         pcplus4D,
    output logic                     validD,
    output logic [5:0]               opD,
    output logic [5:0]               functD,
    output logic [4:0]               rsD,
    output logic [4:0]               rtD,
    output logic [4:0]               rdD,
    output logic [WIDTH-1:0]         rd1D,
    output logic [WIDTH-1:0]         rd2D,
    output logic [WIDTH-1:0]         signimmD,
    output logic [WIDTH-1:0]         pcbranchD,
    output logic                     equalD
);

    localparam int AW = $clog2(NREGS);

    logic [31:0]      instr_q,   instr_d;
    logic [WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic             valid_q,   valid_d;

    // Flush outranks stall so a squashed slot never survives a held pipeline
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flushD) begin
            instr_d   = NOP_INSTR;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (!stallD) begin
            instr_d   = instrF;
            pcplus4_d = pcplus4F;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instrD   = instr_q;
    assign pcplus4D = pcplus4_q;
    assign validD   = valid_q;

    assign opD    = instr_q[31:26];
    assign rsD    = instr_q[25:21];
    assign rtD    = instr_q[20:16];
    assign rdD    = instr_q[15:11];
    assign functD = instr_q[5:0];

    regfile #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (regwriteW),
        .waddr  (writeregW),
        .wdata  (resultW),
        .raddr1 (rsD[AW-1:0]),
        .raddr2 (rtD[AW-1:0]),
        .rdata1 (rd1D),
        .rdata2 (rd2D)
    );

    logic [WIDTH-1:0] cmp_a, cmp_b;

    assign signimmD  = {{(WIDTH-16){instr_q[15]}}, instr_q[15:0]};
    assign pcbranchD = pcplus4_q + (signimmD << 2);

    assign cmp_a  = forwardAD ? aluoutM : rd1D;
    assign cmp_b  = forwardBD ? aluoutM : rd2D;
    assign equalD = (cmp_a == cmp_b);

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode
// Description : Directed scoreboard testbench for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrF, pcplus4F, resultW, aluoutM;
    logic        stallD, flushD, regwriteW, forwardAD, forwardBD;
    logic [4:0]  writeregW;
    logic [31:0] instrD, pcplus4D, rd1D, rd2D, signimmD, pcbranchD;
    logic        validD, equalD;
    logic [5:0]  opD, functD;
    logic [4:0]  rsD, rtD, rdD;

    always #5 clk = ~clk;

    decode dut (
        .clk       (clk),
        .reset     (reset),
        .instrF    (instrF),
        .pcplus4F  (pcplus4F),
        .stallD    (stallD),
        .flushD    (flushD),
        .regwriteW (regwriteW),
        .writeregW (writeregW),
        .resultW   (resultW),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .aluoutM   (aluoutM),
        .instrD    (instrD),
        .pcplus4D  (pcplus4D),
        .validD    (validD),
        .opD       (opD),
        .functD    (functD),
        .rsD       (rsD),
        .rtD       (rtD),
        .rdD       (rdD),
        .rd1D      (rd1D),
        .rd2D      (rd2D),
        .signimmD  (signimmD),
        .pcbranchD (pcbranchD),
        .equalD    (equalD)
    );

    localparam int S_INSTR = 0, S_PC4 = 1, S_VALID = 2, S_RD1 = 3, S_RD2 = 4,
                   S_IMM = 5, S_BR = 6, S_EQ = 7, S_OP = 8, S_RS = 9, S_RT = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_INSTR: return instrD;
            S_PC4:   return pcplus4D;
            S_VALID: return {31'd0, validD};
            S_RD1:   return rd1D;
            S_RD2:   return rd2D;
            S_IMM:   return signimmD;
            S_BR:    return pcbranchD;
            S_EQ:    return {31'd0, equalD};
            S_OP:    return {26'd0, opD};
            S_RS:    return {27'd0, rsD};
            S_RT:    return {27'd0, rtD};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: drains every queued expectation at the falling edge
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = actual(e.sel);
                n_tests++;
                if (a !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, a, e.val);
                end
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        sb.push_back('{name, sel, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; instrF = 32'h2008_0005; pcplus4F = 32'h4;
        stallD = 0; flushD = 0; regwriteW = 0; writeregW = 0; resultW = 0;
        forwardAD = 0; forwardBD = 0; aluoutM = 0;

        // During reset
        expect_v("rst_instr", S_INSTR, 32'h0);
        expect_v("rst_valid", S_VALID, 32'h0);
        expect_v("rst_pc4",   S_PC4,   32'h0);
        expect_v("rst_rd1",   S_RD1,   32'h0);
        expect_v("rst_rd2",   S_RD2,   32'h0);
        expect_v("rst_imm",   S_IMM,   32'h0);
        expect_v("rst_br",    S_BR,    32'h0);
        expect_v("rst_eq",    S_EQ,    32'h1);
        chk();

        // Release reset, first load
        reset = 1'b1;
        tick();
        expect_v("ld_instr", S_INSTR, 32'h2008_0005);
        expect_v("ld_valid", S_VALID, 32'h1);
        expect_v("ld_imm",   S_IMM,   32'h5);
        expect_v("ld_pc4",   S_PC4,   32'h4);
        expect_v("ld_br",    S_BR,    32'h18);
        expect_v("ld_op",    S_OP,    32'h08);
        expect_v("ld_rt",    S_RT,    32'h08);
        chk();

        // beq with negative immediate
        instrF = 32'h1000_FFFF; pcplus4F = 32'h40;
        tick();
        expect_v("beq_imm", S_IMM, 32'hFFFF_FFFF);
        expect_v("beq_br",  S_BR,  32'h3C);
        expect_v("beq_op",  S_OP,  32'h04);
        chk();

        // Flush wins over stall
        instrF = 32'h2008_0005; pcplus4F = 32'h10;
        tick();
        stallD = 1; flushD = 1; instrF = 32'h1234_5678;
        tick();
        expect_v("fl_instr", S_INSTR, 32'h0);
        expect_v("fl_valid", S_VALID, 32'h0);
        expect_v("fl_pc4",   S_PC4,   32'h0);
        expect_v("fl_br",    S_BR,    32'h0);
        chk();
        stallD = 0; flushD = 0;

        // Stall holds for three cycles, then loads
        instrF = 32'h2008_0005; pcplus4F = 32'h10;
        tick();
        stallD = 1;
        for (int i = 0; i < 3; i++) begin
            instrF = 32'h1111_0000 + i; pcplus4F = 32'h100 + 4 * i;
            tick();
            expect_v("st_instr", S_INSTR, 32'h2008_0005);
            expect_v("st_pc4",   S_PC4,   32'h10);
            expect_v("st_valid", S_VALID, 32'h1);
            chk();
        end
        stallD = 0; instrF = 32'h8C10_0004; pcplus4F = 32'h20;
        tick();
        expect_v("unst_instr", S_INSTR, 32'h8C10_0004);
        expect_v("unst_pc4",   S_PC4,   32'h20);
        chk();

        // Write r8 while rsD=8
        instrF = 32'h0109_0000; pcplus4F = 32'h24;
        tick();
        regwriteW = 1; writeregW = 5'd8; resultW = 32'hDEAD_BEEF;
        expect_v("wr_rs", S_RS, 32'h8);
`ifdef DECODE_WB_BYPASS_EN
        expect_v("wr_same", S_RD1, 32'hDEAD_BEEF);
`else
        expect_v("wr_same", S_RD1, 32'h0);
`endif
        tick();
        regwriteW = 0;
        expect_v("wr_next", S_RD1, 32'hDEAD_BEEF);
        expect_v("wr_rd2",  S_RD2, 32'h0);
        chk();

        // Write to r0 is ignored
        instrF = 32'h0008_0000;
        tick();
        regwriteW = 1; writeregW = 5'd0; resultW = 32'hCAFE_F00D;
        expect_v("r0_same", S_RD1, 32'h0);
        expect_v("r0_rt8",  S_RD2, 32'hDEAD_BEEF);
        chk();
        tick();
        regwriteW = 0;
        expect_v("r0_next", S_RD1, 32'h0);
        chk();

        // Branch compare with forwarding
        instrF = 32'h0109_0000;
        regwriteW = 1; writeregW = 5'd9; resultW = 32'h7;
        tick();
        writeregW = 5'd8; resultW = 32'h5;
        tick();
        regwriteW = 0;
        expect_v("cmp_rd1", S_RD1, 32'h5);
        expect_v("cmp_rd2", S_RD2, 32'h7);
        expect_v("cmp_ne",  S_EQ,  32'h0);
        chk();
        forwardBD = 1; aluoutM = 32'h5;
        expect_v("cmp_fwdb", S_EQ, 32'h1);
        chk();
        forwardBD = 0;
        expect_v("cmp_nofwd", S_EQ, 32'h0);
        chk();
        forwardAD = 1; aluoutM = 32'h7;
        expect_v("cmp_fwda", S_EQ, 32'h1);
        chk();
        forwardAD = 0;

        // Reset mid-stall clears state and regfile; loads once released
        reset = 0; stallD = 1;
        #1;
        expect_v("rst2_instr", S_INSTR, 32'h0);
        expect_v("rst2_valid", S_VALID, 32'h0);
        expect_v("rst2_eq",    S_EQ,    32'h1);
        chk();
        forwardAD = 1;
        expect_v("rst2_fwd_eq", S_EQ, 32'h0);
        chk();
        forwardAD = 0;
        reset = 1; stallD = 0; instrF = 32'h0109_0000; pcplus4F = 32'h44;
        tick();
        expect_v("rst2_ld",    S_INSTR, 32'h0109_0000);
        expect_v("rst2_vld",   S_VALID, 32'h1);
        expect_v("rst2_rd1",   S_RD1,   32'h0);
        expect_v("rst2_rd2",   S_RD2,   32'h0);
        chk();

        chk();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
